// File: rtl/bilinear_interp.sv
// Bilinear interpolation stage: blends four neighbour pixels by (fx, fy)
// through a 3-stage pipeline and emits an AXI-stream with frame/line tags.
module bilinear_interp #(
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16,
  parameter int FRAC_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fsync,
  input  logic [7:0]           lu,
  input  logic [7:0]           ru,
  input  logic [7:0]           ld,
  input  logic [7:0]           rd,
  input  logic [FRAC_BITS-1:0] fx,
  input  logic [FRAC_BITS-1:0] fy,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [7:0]           m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic                 m_tuser,
  output logic                 line_err
);

  localparam int HW = 8 + FRAC_BITS + 1;       // horizontal blend width
  localparam int VW = 8 + 2 * FRAC_BITS + 1;   // vertical blend width
  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [FRAC_BITS:0] UNIT  = {1'b1, {FRAC_BITS{1'b0}}};
  localparam logic [VW-1:0]      ROUND = VW'(1) << (2 * FRAC_BITS - 1);

  // Whole pipeline advances together; it only stalls when the output is held.
  logic en;
  logic accept;
  logic tag_user;
  logic tag_last;

  assign en      = !m_tvalid || m_tready;
  assign s_ready = en;
  assign accept  = s_valid && en && !fsync;

  // Framing counters
  logic [XW-1:0] x_cnt_reg;
  logic [YW-1:0] y_cnt_reg;

  assign tag_user = (x_cnt_reg == '0) && (y_cnt_reg == '0);
  assign tag_last = (x_cnt_reg == XW'(IMG_WIDTH - 1));

  // Horizontal blend for the upper (row 0) and lower (row 1) neighbour pairs
  logic [FRAC_BITS:0] wx;
  logic [7:0]         left_px  [2];
  logic [7:0]         right_px [2];
  logic [HW-1:0]      hblend   [2];

  assign wx          = UNIT - {1'b0, fx};
  assign left_px[0]  = lu;
  assign left_px[1]  = ld;
  assign right_px[0] = ru;
  assign right_px[1] = rd;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_hblend
      assign hblend[gi] = HW'(left_px[gi]) * HW'(wx) + HW'(right_px[gi]) * HW'(fx);
    end
  endgenerate

  // Stage 1 registers
  logic                 s1_valid_reg;
  logic [HW-1:0]        s1_top_reg;
  logic [HW-1:0]        s1_bot_reg;
  logic [FRAC_BITS-1:0] s1_fy_reg;
  logic                 s1_last_reg;
  logic                 s1_user_reg;

  // Stage 2 registers
  logic                 s2_valid_reg;
  logic [VW-1:0]        s2_acc_reg;
  logic                 s2_last_reg;
  logic                 s2_user_reg;

  // Vertical blend of the two row results
  logic [FRAC_BITS:0] wy;
  logic [VW-1:0]      vblend;

  assign wy     = UNIT - {1'b0, s1_fy_reg};
  assign vblend = VW'(s1_top_reg) * VW'(wy) + VW'(s1_bot_reg) * VW'(s1_fy_reg);

  // Advance x/y position on every accepted beat; fsync restarts the frame
  always_ff @(posedge clk) begin
    if (rst || fsync) begin
      x_cnt_reg <= '0;
      y_cnt_reg <= '0;
    end else if (accept) begin
      if (tag_last) begin
        x_cnt_reg <= '0;
        if (y_cnt_reg == YW'(IMG_HEIGHT - 1)) begin
          y_cnt_reg <= '0;
        end else begin
          y_cnt_reg <= y_cnt_reg + 1'b1;
        end
      end else begin
        x_cnt_reg <= x_cnt_reg + 1'b1;
      end
    end
  end

  // Sticky flag when upstream end-of-line disagrees with the local column count
  always_ff @(posedge clk) begin
    if (rst || fsync) begin
      line_err <= 1'b0;
    end else if (accept && (s_last != tag_last)) begin
      line_err <= 1'b1;
    end
  end

  // Stage 1: capture horizontal blends, fy and the beat's framing tags
  always_ff @(posedge clk) begin
    if (rst || fsync) begin
      s1_valid_reg <= 1'b0;
    end else if (en) begin
      s1_valid_reg <= s_valid;
    end
    if (en) begin
      s1_top_reg  <= hblend[0];
      s1_bot_reg  <= hblend[1];
      s1_fy_reg   <= fy;
      s1_last_reg <= tag_last;
      s1_user_reg <= tag_user;
    end
  end

  // Stage 2: vertical blend into the full-precision accumulator
  always_ff @(posedge clk) begin
    if (rst || fsync) begin
      s2_valid_reg <= 1'b0;
    end else if (en) begin
      s2_valid_reg <= s1_valid_reg;
    end
    if (en) begin
      s2_acc_reg  <= vblend;
      s2_last_reg <= s1_last_reg;
      s2_user_reg <= s1_user_reg;
    end
  end

  // Stage 3: round to nearest and hold the beat until the sink takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tuser  <= 1'b0;
    end else begin
      if (fsync) begin
        m_tvalid <= 1'b0;
      end else if (en) begin
        m_tvalid <= s2_valid_reg;
      end
      if (en) begin
        m_tdata <= 8'((s2_acc_reg + ROUND) >> (2 * FRAC_BITS));
        m_tlast <= s2_last_reg;
        m_tuser <= s2_user_reg;
      end
    end
  end

endmodule

// File: tb/tb_bilinear_interp.sv
// Bench for bilinear_interp: directed beats, a queue-based golden model of the
// interpolated stream and its framing tags, and literal spot checks.
module tb_bilinear_interp;

  localparam int W = 16;
  localparam int H = 16;
  localparam int F = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fsync = 1'b0;
  logic [7:0]   lu = '0, ru = '0, ld = '0, rd = '0;
  logic [F-1:0] fx = '0, fy = '0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic         m_tready = 1'b1;
  logic         s_ready;
  logic [7:0]   m_tdata;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tuser;
  logic         line_err;

  bilinear_interp #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FRAC_BITS(F)) dut (
    .clk(clk), .rst(rst), .fsync(fsync),
    .lu(lu), .ru(ru), .ld(ld), .rd(rd), .fx(fx), .fy(fy),
    .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .line_err(line_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pix;
    logic       last;
    logic       user;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   mx = 0;
  int   my = 0;
  logic merr = 1'b0;
  int   out_idx = 0;
  int   n_user = 0;
  int   last_idx[$];

  // Weighted sum of the four corners with weights summing to 256, rounded.
  function automatic logic [7:0] golden(input int a, b, c, d, x, y);
    int u;
    int s;
    u = 1 << F;
    s = a * (u - x) * (u - y) + b * x * (u - y) + c * (u - x) * y + d * x * y;
    return 8'((s + 128) / 256);
  endfunction

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare process: checks every output beat and flag against the model
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mx = 0; my = 0; merr = 1'b0;
      out_idx = 0; n_user = 0; last_idx.delete();
    end else begin
      chk(line_err === merr, "line_err", int'(line_err), int'(merr));
      chk(s_ready === (!m_tvalid || m_tready), "s_ready", int'(s_ready), int'(!m_tvalid || m_tready));
      if (m_tvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "spurious_output", int'(m_tdata), -1);
        end else begin
          chk(m_tdata === exp_q[0].pix, "pixel", int'(m_tdata), int'(exp_q[0].pix));
          chk(m_tlast === exp_q[0].last, "tlast", int'(m_tlast), int'(exp_q[0].last));
          chk(m_tuser === exp_q[0].user, "tuser", int'(m_tuser), int'(exp_q[0].user));
          if (m_tready && !fsync) begin
            $display("[TB] out idx=%0d pix=%0d last=%0d user=%0d", out_idx, m_tdata, m_tlast, m_tuser);
            if (m_tuser) n_user++;
            if (m_tlast) last_idx.push_back(out_idx);
            out_idx++;
            void'(exp_q.pop_front());
          end
        end
      end
      if (fsync) begin
        exp_q.delete();
        mx = 0; my = 0; merr = 1'b0;
        out_idx = 0; n_user = 0; last_idx.delete();
      end else if (s_valid && s_ready) begin
        exp_q.push_back('{golden(lu, ru, ld, rd, fx, fy), (mx == W - 1), (mx == 0 && my == 0)});
        if (s_last != (mx == W - 1)) merr = 1'b1;
        if (mx == W - 1) begin
          mx = 0;
          my = (my == H - 1) ? 0 : my + 1;
        end else begin
          mx++;
        end
      end
    end
  end

  task automatic send(input logic [7:0] a, b, c, d, input logic [F-1:0] x, y, input logic last);
    int n;
    n = 0;
    lu = a; ru = b; ld = c; rd = d; fx = x; fy = y; s_last = last; s_valid = 1'b1;
    while (!s_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk(s_ready === 1'b1, "accept_timeout", n, 0);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic expect_pix(input int exp, input string name);
    @(posedge clk); #1;
    chk(m_tvalid === 1'b0, "latency_early", int'(m_tvalid), 0);
    @(posedge clk); #1;
    chk(m_tvalid === 1'b1, "latency_valid", int'(m_tvalid), 1);
    chk(m_tdata === 8'(exp), name, int'(m_tdata), exp);
  endtask

  task automatic pulse_fsync();
    fsync = 1'b1;
    @(posedge clk); #1;
    fsync = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit acc;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk(m_tvalid === 1'b0, "rst_tvalid", int'(m_tvalid), 0);
    chk(m_tdata === 8'd0, "rst_tdata", int'(m_tdata), 0);
    chk(m_tlast === 1'b0, "rst_tlast", int'(m_tlast), 0);
    chk(m_tuser === 1'b0, "rst_tuser", int'(m_tuser), 0);
    chk(line_err === 1'b0, "rst_line_err", int'(line_err), 0);
    chk(s_ready === 1'b1, "rst_s_ready", int'(s_ready), 1);
    rst = 1'b0;

    // Model pinned to hand-computed values
    chk(golden(100, 0, 0, 0, 0, 0) == 8'd100, "model_identity", golden(100, 0, 0, 0, 0, 0), 100);
    chk(golden(0, 255, 0, 255, 8, 0) == 8'd128, "model_half_h", golden(0, 255, 0, 255, 8, 0), 128);
    chk(golden(255, 0, 0, 0, 15, 15) == 8'd1, "model_corner", golden(255, 0, 0, 0, 15, 15), 1);

    // Directed arithmetic, one beat at a time with exact latency
    send(8'd100, 8'd0, 8'd0, 8'd0, 4'd0, 4'd0, 1'b0);
    expect_pix(100, "identity");
    send(8'd0, 8'd255, 8'd0, 8'd255, 4'd8, 4'd0, 1'b0);
    expect_pix(128, "half_horizontal");
    send(8'd255, 8'd255, 8'd0, 8'd0, 4'd0, 4'd8, 1'b0);
    expect_pix(128, "half_vertical");
    send(8'd200, 8'd200, 8'd200, 8'd200, 4'd15, 4'd15, 1'b0);
    expect_pix(200, "max_frac_flat");
    // wx = wy = 1: 255*1*1 = 255, (255 + 128) >> 8 = 1
    send(8'd255, 8'd0, 8'd0, 8'd0, 4'd15, 4'd15, 1'b0);
    expect_pix(1, "max_frac_corner");

    // Framing: two full lines with correct s_last
    pulse_fsync();
    for (int i = 0; i < 2 * W; i++) begin
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), (i % W) == W - 1);
    end
    drain();
    chk(n_user == 1, "tuser_count", n_user, 1);
    chk(last_idx.size() == 2, "tlast_count", last_idx.size(), 2);
    if (last_idx.size() == 2) begin
      chk(last_idx[0] == 15, "tlast_pos0", last_idx[0], 15);
      chk(last_idx[1] == 31, "tlast_pos1", last_idx[1], 31);
    end
    chk(line_err === 1'b0, "line_err_clean", int'(line_err), 0);

    // Premature s_last at x=5
    for (int i = 0; i < 5; i++) send(8'd10, 8'd20, 8'd30, 8'd40, 4'd3, 4'd5, 1'b0);
    send(8'd10, 8'd20, 8'd30, 8'd40, 4'd3, 4'd5, 1'b1);
    chk(line_err === 1'b1, "line_err_set", int'(line_err), 1);
    for (int i = 6; i < W; i++) send(8'd1, 8'd2, 8'd3, 8'd4, 4'd1, 4'd1, i == W - 1);
    drain();
    chk(line_err === 1'b1, "line_err_sticky", int'(line_err), 1);
    pulse_fsync();
    chk(line_err === 1'b0, "line_err_fsync_clear", int'(line_err), 0);

    // Backpressure: continuous input, sink stalls for cycles 10..13
    k = 0;
    acc = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (acc) begin
        lu = 8'($urandom_range(0, 255)); ru = 8'($urandom_range(0, 255));
        ld = 8'($urandom_range(0, 255)); rd = 8'($urandom_range(0, 255));
        fx = 4'($urandom_range(0, 15)); fy = 4'($urandom_range(0, 15));
      end
      m_tready = !(cyc >= 10 && cyc < 14);
      s_valid = 1'b1;
      s_last = (k % W) == W - 1;
      #1;
      if (cyc >= 10 && cyc < 14) chk(s_ready === 1'b0, "bp_s_ready_low", int'(s_ready), 0);
      if (cyc == 14) chk(s_ready === 1'b1, "bp_s_ready_resume", int'(s_ready), 1);
      acc = s_ready;
      @(posedge clk); #1;
      if (acc) k++;
    end
    s_valid = 1'b0;
    m_tready = 1'b1;
    drain();
    chk(out_idx == k, "bp_count", out_idx, k);
    chk(k == 36, "bp_accepted", k, 36);

    // fsync at x=9 with a beat presented in the same cycle
    pulse_fsync();
    for (int i = 0; i < 3; i++) send(8'd5, 8'd6, 8'd7, 8'd8, 4'd2, 4'd2, 1'b0);
    send(8'd5, 8'd6, 8'd7, 8'd8, 4'd2, 4'd2, 1'b1);
    for (int i = 4; i < 9; i++) send(8'd9, 8'd9, 8'd9, 8'd9, 4'd4, 4'd4, 1'b0);
    chk(m_tvalid === 1'b1, "pre_fsync_valid", int'(m_tvalid), 1);
    lu = 8'd77; ru = 8'd77; ld = 8'd77; rd = 8'd77; s_last = 1'b0; s_valid = 1'b1;
    pulse_fsync();
    s_valid = 1'b0;
    chk(m_tvalid === 1'b0, "fsync_flush", int'(m_tvalid), 0);
    chk(line_err === 1'b0, "fsync_line_err", int'(line_err), 0);
    send(8'd50, 8'd50, 8'd50, 8'd50, 4'd3, 4'd7, 1'b0);
    expect_pix(50, "post_fsync_pixel");
    chk(m_tuser === 1'b1, "post_fsync_tuser", int'(m_tuser), 1);
    drain();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
